// File: rtl/keypad_event_ctrl.sv
// 4x4 keypad scanner: row strobing, column sampling, whole-frame debounce and
// a queue of press/release events behind a valid/ready handshake.
module keypad_event_ctrl #(
    parameter int SCAN_DIV   = 5000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_state,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_code,
    output logic        ev_press,
    output logic        overflow,
    input  logic        clr_ovf
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    // ---------------- column synchroniser ----------------
    logic [3:0] col_meta, col_sync;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // ---------------- row scan and frame capture ----------------
    logic [PW-1:0] phase_cnt;
    logic          tc;
    logic [1:0]    ridx;
    logic [15:0]   raw;
    logic          eval_f;

    assign tc = (phase_cnt == TC);

    always_comb begin
        case (row)
            4'b1101: ridx = 2'd1;
            4'b1011: ridx = 2'd2;
            4'b0111: ridx = 2'd3;
            default: ridx = 2'd0;
        endcase
    end

    // eval_f marks cycle F, the cycle after the last row of a frame is sampled
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            phase_cnt <= '0;
            row       <= 4'b1110;
            raw       <= '0;
            eval_f    <= 1'b0;
        end else begin
            phase_cnt <= tc ? '0 : phase_cnt + 1'b1;
            eval_f    <= tc && (ridx == 2'd3);
            if (tc) begin
                row                    <= {row[2:0], row[3]};
                raw[{ridx, 2'b00} +: 4] <= ~col_sync;
            end
        end
    end

    // ---------------- debounce and commit ----------------
    logic [15:0] prev_raw;
    logic [3:0]  stable_cnt, cnt_next;
    logic        commit;

    always_comb begin
        if (raw != prev_raw)
            cnt_next = 4'd1;
        else if (stable_cnt == 4'd15)
            cnt_next = 4'd15;
        else
            cnt_next = stable_cnt + 4'd1;
        commit = eval_f && (cnt_next >= DB) && (raw != key_state);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            prev_raw   <= '0;
            stable_cnt <= '0;
            key_state  <= '0;
        end else begin
            if (eval_f) begin
                prev_raw   <= raw;
                stable_cnt <= cnt_next;
            end
            if (commit)
                key_state <= raw;
        end
    end

    // ---------------- event emitter ----------------
    state_t      state, state_next;
    logic [15:0] diff, diff_next;
    logic [3:0]  low_idx;
    logic        push;
    logic        push_press;

    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (diff[i]) low_idx = 4'(i);
    end

    // key_state already holds the committed frame, so it supplies the press
    // polarity even if raw is overwritten by the next frame mid-emit
    assign diff_next  = diff & ~(16'd1 << low_idx);
    assign push_press = key_state[low_idx];

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: if (commit) state_next = EMIT;
            EMIT: begin
                push = 1'b1;
                if (diff_next == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            diff  <= '0;
        end else begin
            state <= state_next;
            if (commit)
                diff <= raw ^ key_state;
            else if (state == EMIT)
                diff <= diff_next;
        end
    end

    // ---------------- event queue ----------------
    logic [FIFO_DEPTH-1:0][4:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;
    logic                       full, pop, wr_en;

    assign full     = (count == FULL_CNT);
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    assign wr_en    = push && (!full || pop);
    assign {ev_code, ev_press} = mem[rd_ptr];

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {low_idx, push_press};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: keypad matrix model, table of held key patterns,
// event scoreboard, plus overflow and mid-emit reset sequences.
module tb_keypad_event_ctrl;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_state;
    logic        ev_valid, ev_ready, ev_press, overflow, clr_ovf;
    logic [3:0]  ev_code;

    logic [15:0] keys;
    logic [3:0]  row_d;
    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          pop_at[16];

    typedef struct {
        logic [3:0] code;
        logic       press;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [15:0] exp_state;
    } vec_t;
    vec_t vecs[7];

    keypad_event_ctrl #(.SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .RSTn(RSTn), .col(col), .row(row), .key_state(key_state),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_press(ev_press), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        row_d <= row;
    end

    // matrix: a closed key pulls its column low while its row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (keys[4*r+c]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (RSTn && ev_valid && ev_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event: got code=%0d press=%0d, none expected", ev_code, ev_press);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (ev_code !== e.code || ev_press !== e.press) begin
                    failed++;
                    $display("FAIL event: got code=%0d press=%0d expected code=%0d press=%0d",
                             ev_code, ev_press, e.code, e.press);
                end
                pop_at[ev_code] = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(row == 4'b1110 && row_d == 4'b0111) && t < 100);
            if (t >= 100) begin
                tests++;
                failed++;
                $display("FAIL frame_timeout: got no frame start within %0d cycles, expected one", t);
            end
        end
    endtask

    // called at the negedge on which reset is released
    task automatic check_rows();
        for (int k = 0; k < 40; k++) begin
            logic [3:0] e = 4'b1110;
            if (k > 0) @(negedge clk);
            for (int j = 0; j < k / 8; j++) e = {e[2:0], e[3]};
            check("row_seq", {28'd0, row}, {28'd0, e});
        end
    endtask

    task automatic push_events(input logic [15:0] old_s, input logic [15:0] new_s);
        for (int i = 0; i < 16; i++)
            if (old_s[i] != new_s[i]) begin
                ev_t e;
                e.code  = 4'(i);
                e.press = new_s[i];
                exp_q.push_back(e);
            end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ev_ready = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] model;
        int t;

        vecs[0] = '{16'h0000, 3, 16'h0000};
        vecs[1] = '{16'h0020, 3, 16'h0020};
        vecs[2] = '{16'h0000, 3, 16'h0000};
        vecs[3] = '{16'h0020, 1, 16'h0000};
        vecs[4] = '{16'h0000, 3, 16'h0000};
        vecs[5] = '{16'h2004, 3, 16'h2004};
        vecs[6] = '{16'h0000, 3, 16'h0000};

        RSTn = 1'b0; keys = '0; ev_ready = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, row}, 32'he);
        check("rst_key_state", {16'd0, key_state}, 32'h0);
        check("rst_ev_valid", {31'd0, ev_valid}, 32'h0);
        check("rst_ev_code", {28'd0, ev_code}, 32'h0);
        check("rst_ev_press", {31'd0, ev_press}, 32'h0);
        check("rst_overflow", {31'd0, overflow}, 32'h0);
        RSTn = 1'b1;
        check_rows();
        wait_frames(1);

        model = '0;
        for (int i = 0; i < 7; i++) begin
            keys = vecs[i].keys;
            push_events(model, vecs[i].exp_state);
            model = vecs[i].exp_state;
            wait_frames(vecs[i].frames);
            check("vec_key_state", {16'd0, key_state}, {16'd0, vecs[i].exp_state});
            if (i == 5) check("consec_2_13", 32'(pop_at[13] - pop_at[2]), 32'd1);
        end
        check("table_drained", 32'(exp_q.size()), 32'd0);

        // queue overflow with the consumer stalled
        set_ready(1'b0);
        wait_frames(1);
        keys = 16'h001F;
        push_events(16'h0000, 16'h000F);
        wait_frames(3);
        check("ovf_key_state", {16'd0, key_state}, 32'h001F);
        check("ovf_set", {31'd0, overflow}, 32'h1);
        check("ovf_valid", {31'd0, ev_valid}, 32'h1);
        repeat (3) @(negedge clk);
        check("hold_code", {28'd0, ev_code}, 32'h0);
        check("hold_press", {31'd0, ev_press}, 32'h1);
        set_ready(1'b1);
        repeat (10) @(negedge clk);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'h1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'h0);
        wait_frames(1);
        keys = 16'h0000;
        push_events(16'h001F, 16'h0000);
        wait_frames(3);
        check("ovf_release_state", {16'd0, key_state}, 32'h0);

        // reset while a 4-key commit is being emitted
        set_ready(1'b0);
        wait_frames(1);
        keys = 16'h000F;
        t = 0;
        while (!ev_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("emit_seen", {31'd0, ev_valid}, 32'h1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_row", {28'd0, row}, 32'he);
        check("mid_rst_key_state", {16'd0, key_state}, 32'h0);
        check("mid_rst_valid", {31'd0, ev_valid}, 32'h0);
        check("mid_rst_code", {28'd0, ev_code}, 32'h0);
        check("mid_rst_press", {31'd0, ev_press}, 32'h0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'h0);
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        check_rows();
        set_ready(1'b1);
        wait_frames(4);
        check("post_rst_key_state", {16'd0, key_state}, 32'h0);
        check("post_rst_valid", {31'd0, ev_valid}, 32'h0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
